// File: rtl/rv32_ctrl_decode.sv
// ============================================================================
//  Module   : rv32_ctrl_decode
//  Brief    : Registered RV32I main + ALU-control decoder, one cycle latency.
//             Optional illegal_instr port enabled by CTRL_ILLEGAL_DETECT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32_ctrl_decode (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        branch,
   output logic        jump,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic [3:0]  alu_ctl,
   output logic [1:0]  pc_src,
`ifdef CTRL_ILLEGAL_DETECT_EN
   output logic        illegal_instr,
`endif
   output logic [2:0]  imm_type
);

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic [1:0] alu_op;
      logic [3:0] alu_ctl;
      logic [1:0] pc_src;
      logic [2:0] imm_type;
   } ctrl_t;

   localparam logic [3:0] c_ALU_AND  = 4'b0000;
   localparam logic [3:0] c_ALU_OR   = 4'b0001;
   localparam logic [3:0] c_ALU_ADD  = 4'b0010;
   localparam logic [3:0] c_ALU_XOR  = 4'b0011;
   localparam logic [3:0] c_ALU_SLL  = 4'b0100;
   localparam logic [3:0] c_ALU_SRL  = 4'b0101;
   localparam logic [3:0] c_ALU_SUB  = 4'b0110;
   localparam logic [3:0] c_ALU_SLT  = 4'b0111;
   localparam logic [3:0] c_ALU_SLTU = 4'b1000;
   localparam logic [3:0] c_ALU_SRA  = 4'b1001;

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_IALU   = 7'b0010011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;

   localparam logic [6:0] c_F7_BASE = 7'b0000000;
   localparam logic [6:0] c_F7_ALT  = 7'b0100000;

   localparam ctrl_t c_NOP = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                               mem_to_reg: 1'b0, branch: 1'b0, jump: 1'b0,
                               alu_src: 1'b0, alu_op: 2'b00, alu_ctl: c_ALU_ADD,
                               pc_src: 2'b00, imm_type: 3'b111};

   // Base funct3 map shared by register and immediate ALU forms.
   function automatic logic [3:0] f3_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_alu = c_ALU_ADD;
         3'b001:  f3_alu = c_ALU_SLL;
         3'b010:  f3_alu = c_ALU_SLT;
         3'b011:  f3_alu = c_ALU_SLTU;
         3'b100:  f3_alu = c_ALU_XOR;
         3'b101:  f3_alu = c_ALU_SRL;
         3'b110:  f3_alu = c_ALU_OR;
         default: f3_alu = c_ALU_AND;
      endcase
   endfunction

   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   ctrl_t      w_dec;
   ctrl_t      w_out;
   logic       w_bad;
   ctrl_t      r_ctrl;

   assign w_opcode = instr[6:0];
   assign w_f3     = instr[14:12];
   assign w_f7     = instr[31:25];

   always_comb begin
      w_dec = c_NOP;
      w_bad = 1'b0;
      case (w_opcode)
         c_OP_R: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = 2'b10;
         end
         c_OP_IALU: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = 2'b11;
            w_dec.imm_type  = 3'b000;
         end
         c_OP_LOAD: begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.imm_type   = 3'b000;
         end
         c_OP_STORE: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.imm_type  = 3'b001;
         end
         c_OP_BRANCH: begin
            w_dec.branch   = 1'b1;
            w_dec.alu_op   = 2'b01;
            w_dec.pc_src   = 2'b01;
            w_dec.imm_type = 3'b010;
         end
         c_OP_JAL: begin
            w_dec.reg_write = 1'b1;
            w_dec.jump      = 1'b1;
            w_dec.pc_src    = 2'b10;
            w_dec.imm_type  = 3'b100;
         end
         c_OP_JALR: begin
            w_dec.reg_write = 1'b1;
            w_dec.jump      = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.pc_src    = 2'b11;
            w_dec.imm_type  = 3'b000;
            w_bad           = (w_f3 != 3'b000);
         end
         default: w_bad = 1'b1;
      endcase

      case (w_dec.alu_op)
         2'b01: begin
            case (w_f3)
               3'b000, 3'b001: w_dec.alu_ctl = c_ALU_SUB;
               3'b100, 3'b101: w_dec.alu_ctl = c_ALU_SLT;
               3'b110, 3'b111: w_dec.alu_ctl = c_ALU_SLTU;
               default:        w_bad = 1'b1;
            endcase
         end
         2'b10: begin
            if (w_f7 == c_F7_BASE) begin
               w_dec.alu_ctl = f3_alu(w_f3);
            end else if (w_f7 == c_F7_ALT && w_f3 == 3'b000) begin
               w_dec.alu_ctl = c_ALU_SUB;
            end else if (w_f7 == c_F7_ALT && w_f3 == 3'b101) begin
               w_dec.alu_ctl = c_ALU_SRA;
            end else begin
               w_bad = 1'b1;
            end
         end
         2'b11: begin
            // Immediate forms reuse funct7 as immediate bits except for shifts.
            w_dec.alu_ctl = f3_alu(w_f3);
            if (w_f3 == 3'b001 && w_f7 != c_F7_BASE) begin
               w_bad = 1'b1;
            end else if (w_f3 == 3'b101) begin
               if (w_f7 == c_F7_ALT) begin
                  w_dec.alu_ctl = c_ALU_SRA;
               end else if (w_f7 != c_F7_BASE) begin
                  w_bad = 1'b1;
               end
            end
         end
         default: w_dec.alu_ctl = c_ALU_ADD;
      endcase

      w_out = w_bad ? c_NOP : w_dec;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !instr_valid) begin
         r_ctrl <= c_NOP;
      end else begin
         r_ctrl <= w_out;
      end
   end

`ifdef CTRL_ILLEGAL_DETECT_EN
   logic r_illegal;

   always_ff @(posedge clk) begin
      if (!rst_n || !instr_valid) begin
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_bad;
      end
   end

   assign illegal_instr = r_illegal;
`endif

   assign reg_write  = r_ctrl.reg_write;
   assign mem_read   = r_ctrl.mem_read;
   assign mem_write  = r_ctrl.mem_write;
   assign mem_to_reg = r_ctrl.mem_to_reg;
   assign branch     = r_ctrl.branch;
   assign jump       = r_ctrl.jump;
   assign alu_src    = r_ctrl.alu_src;
   assign alu_op     = r_ctrl.alu_op;
   assign alu_ctl    = r_ctrl.alu_ctl;
   assign pc_src     = r_ctrl.pc_src;
   assign imm_type   = r_ctrl.imm_type;

endmodule

`default_nettype wire

// File: tb/tb_rv32_ctrl_decode.sv
// ============================================================================
//  Module   : tb_rv32_ctrl_decode
//  Brief    : Directed self-checking bench for rv32_ctrl_decode.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32_ctrl_decode;

   // Expected vector layout:
   // {reg_write,mem_read,mem_write,mem_to_reg,branch,jump,alu_src}_aluop_aluctl_pcsrc_imm
   localparam logic [17:0] c_NOP  = 18'b0000000_00_0010_00_111;
   localparam logic [17:0] c_ADD  = 18'b1000000_10_0010_00_111;
   localparam logic [17:0] c_SUB  = 18'b1000000_10_0110_00_111;
   localparam logic [17:0] c_AND  = 18'b1000000_10_0000_00_111;
   localparam logic [17:0] c_SRA  = 18'b1000000_10_1001_00_111;
   localparam logic [17:0] c_LW   = 18'b1101001_00_0010_00_000;
   localparam logic [17:0] c_SW   = 18'b0010001_00_0010_00_001;
   localparam logic [17:0] c_BEQ  = 18'b0000100_01_0110_01_010;
   localparam logic [17:0] c_BGE  = 18'b0000100_01_0111_01_010;
   localparam logic [17:0] c_BLTU = 18'b0000100_01_1000_01_010;
   localparam logic [17:0] c_ADDI = 18'b1000001_11_0010_00_000;
   localparam logic [17:0] c_XORI = 18'b1000001_11_0011_00_000;
   localparam logic [17:0] c_SRAI = 18'b1000001_11_1001_00_000;
   localparam logic [17:0] c_JAL  = 18'b1000010_00_0010_10_100;
   localparam logic [17:0] c_JALR = 18'b1000011_00_0010_11_000;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src;
   logic [1:0]  alu_op;
   logic [3:0]  alu_ctl;
   logic [1:0]  pc_src;
   logic [2:0]  imm_type;
`ifdef CTRL_ILLEGAL_DETECT_EN
   logic        illegal_instr;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   rv32_ctrl_decode dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .reg_write   (reg_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_to_reg  (mem_to_reg),
      .branch      (branch),
      .jump        (jump),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .alu_ctl     (alu_ctl),
      .pc_src      (pc_src),
`ifdef CTRL_ILLEGAL_DETECT_EN
      .illegal_instr (illegal_instr),
`endif
      .imm_type    (imm_type)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at the falling edge, then sample just after the rising edge.
   task automatic step(input string tag, input logic rst_val, input logic valid,
                       input logic [31:0] ins, input logic [17:0] exp,
                       input logic exp_ill);
      @(negedge clk);
      rst_n       = rst_val;
      instr_valid = valid;
      instr       = ins;
      @(posedge clk);
      #1;
      chk(tag, {14'd0, reg_write, mem_read, mem_write, mem_to_reg, branch, jump,
                alu_src, alu_op, alu_ctl, pc_src, imm_type}, {14'd0, exp});
`ifdef CTRL_ILLEGAL_DETECT_EN
      chk({tag, "_ill"}, {31'd0, illegal_instr}, {31'd0, exp_ill});
`else
      if (exp_ill) begin end
`endif
   endtask

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b1;
      instr       = 32'h0000_0033;
      repeat (2) @(posedge clk);

      step("reset_hold_add", 1'b0, 1'b1, 32'h0000_0033, c_NOP,  1'b0);
      step("add",            1'b1, 1'b1, 32'h0000_0033, c_ADD,  1'b0);
      step("invalid_add",    1'b1, 1'b0, 32'h0000_0033, c_NOP,  1'b0);
      step("sub",            1'b1, 1'b1, 32'h4000_0033, c_SUB,  1'b0);
      step("r_f7_01",        1'b1, 1'b1, 32'h0200_0033, c_NOP,  1'b1);
      step("and",            1'b1, 1'b1, 32'h0000_7033, c_AND,  1'b0);
      step("sra",            1'b1, 1'b1, 32'h4000_5033, c_SRA,  1'b0);
      step("r_sll_alt_f7",   1'b1, 1'b1, 32'h4000_1033, c_NOP,  1'b1);
      step("lw",             1'b1, 1'b1, 32'h0000_2003, c_LW,   1'b0);
      step("sw",             1'b1, 1'b1, 32'h0000_2023, c_SW,   1'b0);
      step("beq",            1'b1, 1'b1, 32'h0000_0063, c_BEQ,  1'b0);
      step("bge",            1'b1, 1'b1, 32'h0000_5063, c_BGE,  1'b0);
      step("bltu",           1'b1, 1'b1, 32'h0000_6063, c_BLTU, 1'b0);
      step("branch_f3_010",  1'b1, 1'b1, 32'h0000_2063, c_NOP,  1'b1);
      step("addi",           1'b1, 1'b1, 32'h0000_0013, c_ADDI, 1'b0);
      step("addi_fff",       1'b1, 1'b1, 32'hFFF0_0013, c_ADDI, 1'b0);
      step("xori_hi_imm",    1'b1, 1'b1, 32'hFE00_4013, c_XORI, 1'b0);
      step("srai",           1'b1, 1'b1, 32'h4000_5013, c_SRAI, 1'b0);
      step("slli_alt_f7",    1'b1, 1'b1, 32'h4000_1013, c_NOP,  1'b1);
      step("shift_bad_f7",   1'b1, 1'b1, 32'h2000_5013, c_NOP,  1'b1);
      step("jal",            1'b1, 1'b1, 32'h0000_006F, c_JAL,  1'b0);
      step("jalr",           1'b1, 1'b1, 32'h0000_0067, c_JALR, 1'b0);
      step("jalr_f3_001",    1'b1, 1'b1, 32'h0000_1067, c_NOP,  1'b1);
      step("lui_unknown",    1'b1, 1'b1, 32'h0000_0037, c_NOP,  1'b1);
      step("jal_again",      1'b1, 1'b1, 32'h0000_006F, c_JAL,  1'b0);
      step("reset_midstream",1'b0, 1'b1, 32'h0000_006F, c_NOP,  1'b0);
      step("after_reset",    1'b1, 1'b1, 32'h0000_2003, c_LW,   1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rv32_ctrl_decode.md
# rv32_ctrl_decode

Registered RV32I control decoder for the processor core. Combines the main opcode decoder and the ALU-control decoder in one block. Takes a 32-bit instruction and produces datapath control signals: write-back, memory, branch/jump, ALU source and operation, PC source, and immediate format. Outputs are registered, with one cycle of latency.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- instr_valid  in  1  instr is a valid instruction this cycle
- instr  in  32  instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
- reg_write  out  1  write the register file
- mem_read  out  1  data-memory read
- mem_write  out  1  data-memory write
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU/PC+4
- branch  out  1  conditional branch instruction
- jump  out  1  JAL/JALR; write-back data is PC+4
- alu_src  out  1  ALU operand B: 1 = immediate, 0 = rs2
- alu_op  out  2  class: 00 add (addressing/jump), 01 branch compare, 10 R-type, 11 I-type ALU
- alu_ctl  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 SRA
- pc_src  out  2  00 PC+4, 01 branch target (taken if compare passes), 10 JAL target, 11 JALR target
- imm_type  out  3  000 I, 001 S, 010 B, 011 U (reserved), 100 J, 111 none
- illegal_instr  out  1  present only with CTRL_ILLEGAL_DETECT_EN

## Operation
NOP vector: all 1-bit outputs 0, alu_op 00, alu_ctl 0010, pc_src 00, imm_type 111.

Main decode, by opcode:
- 0110011 R: reg_write, alu_op 10, imm 111
- 0010011 I-ALU: reg_write, alu_src, alu_op 11, imm 000
- 0000011 LOAD: reg_write, mem_read, mem_to_reg, alu_src, alu_op 00, imm 000
- 0100011 STORE: mem_write, alu_src, alu_op 00, imm 001
- 1100011 BRANCH: branch, alu_op 01, pc_src 01, imm 010
- 1101111 JAL: reg_write, jump, alu_op 00, pc_src 10, imm 100
- 1100111 JALR (funct3 000): reg_write, jump, alu_src, alu_op 00, pc_src 11, imm 000
- any other opcode: NOP vector

ALU control:
- alu_op 00: ADD.
- alu_op 01: by funct3.
  - 000/001 (BEQ/BNE): SUB
  - 100/101: SLT
  - 110/111: SLTU
  - 010/011: NOP vector (illegal)
- alu_op 10: by funct3.
  - 000: ADD, or SUB if funct7 = 0100000
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA if funct7 = 0100000
  - 110: OR
  - 111: AND
  - funct7 other than 0000000/0100000, or 0100000 with any funct3 other than 000/101: NOP vector (illegal)
- alu_op 11: same funct3 map as alu_op 10, with these differences.
  - funct7 is ignored except for shifts; funct3 000 is always ADD.
  - 001 requires funct7 0000000.
  - 101 with funct7 0100000 gives SRA, with 0000000 gives SRL, otherwise illegal.

Illegal instructions always produce the NOP vector. This guarantees no architectural side effects.

## Timing
- On each rising clk edge:
  - rst_n = 0: all outputs load the NOP vector (illegal_instr = 0)
  - else instr_valid = 0: NOP vector
  - else: decode of instr
- Latency: exactly 1 cycle from instr to outputs. There is no handshake and no stall; a new instruction is accepted every cycle.
- Reset has priority over instr_valid. Asserting reset mid-stream discards the in-flight decode on that edge.
- Decode is pure combinational logic feeding one register stage. No other state.

## Configuration
- CTRL_ILLEGAL_DETECT_EN defined: port illegal_instr exists. It registers 1 for any valid instruction that decodes as illegal (unknown opcode, bad funct3/funct7), and 0 otherwise, on reset, or when instr_valid = 0.
- Undefined: port absent. Illegal instructions still decode silently to the NOP vector.

## Test plan
- ADD 0x00000033 -> next cycle: reg_write 1, mem_* 0, mem_to_reg 0, branch 0, alu_src 0, alu_ctl 0010, pc_src 00, imm_type 111.
- SUB 0x40000033 -> alu_ctl 0110, other outputs as ADD; funct7 0x01 -> NOP vector, illegal_instr 1.
- LW 0x00002003 -> reg_write 1, mem_read 1, mem_to_reg 1, alu_src 1, alu_ctl 0010, imm 000. SW 0x00002023 -> mem_write 1, alu_src 1, reg_write 0, alu_ctl 0010, imm 001.
- BEQ 0x00000063 -> branch 1, alu_ctl 0110, pc_src 01, imm 010. BLTU (funct3 110) -> alu_ctl 1000.
- ADDI 0x00000013 -> reg_write 1, alu_src 1, alu_ctl 0010, imm 000. ADDI with imm 0xFFF (0xFFF00013) -> still ADD. SRAI 0x40005013 -> 1001.
- Reset/valid: hold rst_n 0 with a valid ADD -> NOP vector. Release, then drop instr_valid -> NOP vector next edge. JAL 0x0000006F -> jump 1, pc_src 10, imm 100.
